hex_display_scanner: RTL



---
 rtl/hex_display_scanner_pkg.sv | 23 ++
 rtl/hex_display_scanner_if.sv | 14 +
 rtl/hex_display_scanner_hex7seg_lut.sv | 11 +
 rtl/hex_display_scanner.sv | 113 +++++++++++
 4 files changed

// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and types for the hex display scanner: segment encodings,
// blanking literals and the per-slot scan state.
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  // Active-low segments, bit6 = g .. bit0 = a; entry k is the glyph for hex digit k.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load channel into the scanner: a 16-bit value plus per-digit decimal points
// offered over valid/ready.
interface hex_display_scanner_if;
  import hex_display_pkg::*;

  logic                  load_valid;
  logic                  load_ready;
  logic [15:0]           load_data;
  logic [NUM_DIGITS-1:0] dp_in;

  modport master (output load_valid, load_data, dp_in, input load_ready);
  modport slave  (input load_valid, load_data, dp_in, output load_ready);

endinterface

// File: rtl/hex_display_scanner_hex7seg_lut.sv
// Combinational hex nibble to active-low 7-segment decode.
module hex7seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb seg = SEG_CODES[nib];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with a one-deep
// pending load slot that is committed to the display only at frame boundaries.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int unsigned DWELL    = 50000,
  parameter int unsigned GUARD    = 2,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_display_scanner_if.slave load,
  input  logic                 disp_en,
  output logic [6:0]           seg,
  output logic                 dp_n,
  output logic [3:0]           an_n,
  output logic [1:0]           digit_idx,
  output logic                 frame_start
);

  localparam int unsigned   CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] DRIVE_END = CW'(DWELL - GUARD);

  logic [CW-1:0]         cnt;
  logic [1:0]            idx;
  logic [15:0]           disp_data;
  logic [15:0]           pend_data;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend;
  logic                  slot_end;
  logic                  frame_end;
  logic                  xfer;
  logic                  blanked;
  logic [15:0]           upper;
  logic [3:0]            nib;
  logic [6:0]            seg_dec;
  scan_state_t           state;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 2'd3);
    xfer      = load.load_valid && !pend;
    state     = (cnt < DRIVE_END) ? ST_DRIVE : ST_GUARD;
    nib       = disp_data[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every more-significant nibble are zero.
    upper     = disp_data >> {idx, 2'b00};
    blanked   = (BLANK_LZ != 0) && (idx != 2'd0) && (upper == '0);
  end

  assign load.load_ready = ~pend;

  hex7seg_lut u_lut (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load accepted on the boundary edge lands in pending only, so it waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (frame_end && pend) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend      <= 1'b0;
      end
      if (xfer) begin
        pend_data <= load.load_data;
        pend_dp   <= load.dp_in;
        pend      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg         <= SEG_BLANK;
      dp_n        <= 1'b1;
      an_n        <= AN_OFF;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      digit_idx   <= idx;
      frame_start <= (cnt == '0) && (idx == 2'd0);
      if (state == ST_DRIVE) begin
        seg  <= seg_dec;
        dp_n <= ~disp_dp[idx];
        an_n <= (!disp_en || blanked) ? AN_OFF : ~(4'b0001 << idx);
      end else begin
        an_n <= AN_OFF;
      end
    end
  end

endmodule
